// File: rtl/state_machine_pkg.sv
// Shared types and defaults for the drink dispenser controller.
//   state_t         : controller state encoding
//   RUN_TIMEOUT_DEF : default maximum pump-on time in clk cycles
package state_machine_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READY = 3'd1,
    RUN   = 3'd2,
    DONE  = 3'd3,
    FAULT = 3'd4
  } state_t;

  localparam int unsigned RUN_TIMEOUT_DEF = 1000;

endpackage

// File: rtl/state_machine.sv
// Moore controller for a single-cup drink dispenser with a run-timeout guard.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : synchronous active-low reset
//   C     : cup present
//   S     : start request (level)
//   V     : vessel full (only examined while filling)
//   LEDS  : "press start" lamp
//   LEDC  : "insert cup" lamp
//   M     : pump motor enable
module state_machine
  import state_machine_pkg::*;
#(
  parameter int unsigned RUN_TIMEOUT = RUN_TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic C,
  input  logic S,
  input  logic V,
  output logic LEDS,
  output logic LEDC,
  output logic M
);

  localparam int unsigned CNT_W = $clog2(RUN_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RUN_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(RUN_TIMEOUT);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ledc_q, ledc_d;
  logic             leds_q, leds_d;
  logic             m_q, m_d;

  // State, run counter and decoded lamp/motor flops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ledc_q  <= 1'b1;
      leds_q  <= 1'b0;
      m_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ledc_q  <= ledc_d;
      leds_q  <= leds_d;
      m_q     <= m_d;
    end
  end

  // Next state; counter is zero outside RUN so RUN entry always starts from 0.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      IDLE: begin
        if (C) state_d = READY;
      end
      READY: begin
        if (!C)     state_d = IDLE;
        else if (S) state_d = RUN;
      end
      RUN: begin
        if (!C)                   state_d = FAULT;
        else if (V)               state_d = DONE;
        else if (cnt_q == CNT_LAST) state_d = FAULT;
        else begin
          state_d = RUN;
          cnt_d   = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (!C) state_d = IDLE;
      end
      FAULT: begin
        if (!C && !S) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode of the next state, so the flops show the new state's outputs.
  always_comb begin
    ledc_d = 1'b1;
    leds_d = 1'b0;
    m_d    = 1'b0;
    case (state_d)
      IDLE:    begin ledc_d = 1'b1; leds_d = 1'b0; m_d = 1'b0; end
      READY:   begin ledc_d = 1'b0; leds_d = 1'b1; m_d = 1'b0; end
      RUN:     begin ledc_d = 1'b0; leds_d = 1'b0; m_d = 1'b1; end
      DONE:    begin ledc_d = 1'b0; leds_d = 1'b0; m_d = 1'b0; end
      FAULT:   begin ledc_d = 1'b1; leds_d = 1'b1; m_d = 1'b0; end
      default: begin ledc_d = 1'b1; leds_d = 1'b0; m_d = 1'b0; end
    endcase
  end

  assign LEDC = ledc_q;
  assign LEDS = leds_q;
  assign M    = m_q;

endmodule

// File: tb/tb_state_machine.sv
// Scoreboard bench for state_machine: each driven cycle pushes the expected
// {LEDC,LEDS,M} for the following edge; a monitor pops and compares after it.
module tb_state_machine;

  localparam int unsigned RT = 8;

  logic clk;
  logic rst_n;
  logic c, s, v;
  logic leds, ledc, m;

  typedef struct {
    string      tag;
    logic [2:0] outs;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  state_machine #(.RUN_TIMEOUT(RT)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .C    (c),
    .S    (s),
    .V    (v),
    .LEDS (leds),
    .LEDC (ledc),
    .M    (m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive inputs for the next edge and queue the outputs expected after it.
  task automatic drive(input string tag, input logic r, input logic ci, input logic si,
                       input logic vi, input logic [2:0] exp_outs);
    exp_t e;
    @(negedge clk);
    rst_n = r;
    c     = ci;
    s     = si;
    v     = vi;
    e.tag  = tag;
    e.outs = exp_outs;
    sb_q.push_back(e);
  endtask

  // Monitor: compare outputs just after each rising edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check(e.tag, 32'({ledc, leds, m}), 32'(e.outs));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // {LEDC,LEDS,M}
  localparam logic [2:0] O_IDLE  = 3'b100;
  localparam logic [2:0] O_READY = 3'b010;
  localparam logic [2:0] O_RUN   = 3'b001;
  localparam logic [2:0] O_DONE  = 3'b000;
  localparam logic [2:0] O_FAULT = 3'b110;

  initial begin
    rst_n = 1'b0;
    c = 1'b0; s = 1'b0; v = 1'b0;

    // Reset and idle
    drive("rst0", 0, 0, 0, 0, O_IDLE);
    drive("rst1", 0, 0, 0, 0, O_IDLE);
    drive("idle0", 1, 0, 0, 0, O_IDLE);
    drive("idle1", 1, 0, 0, 0, O_IDLE);

    // Normal fill: 5 RUN cycles then V
    drive("nf_ready", 1, 1, 0, 0, O_READY);
    drive("nf_ready_hold", 1, 1, 0, 0, O_READY);
    drive("nf_run0", 1, 1, 1, 0, O_RUN);
    for (int i = 1; i < 5; i++) drive("nf_run", 1, 1, 0, 0, O_RUN);
    drive("nf_done", 1, 1, 0, 1, O_DONE);
    drive("nf_idle", 1, 0, 0, 0, O_IDLE);

    // Cup arrives with S already high, V unknown
    drive("sh_ready", 1, 1, 1, 1'bx, O_READY);
    drive("sh_run", 1, 1, 1, 1'bx, O_RUN);
    drive("sh_run_hold", 1, 1, 0, 0, O_RUN);
    drive("sh_done", 1, 1, 0, 1, O_DONE);

    // DONE with S held: no restart until cup cycles
    for (int i = 0; i < 3; i++) drive("done_s_held", 1, 1, 1, 0, O_DONE);
    drive("done_cup_out", 1, 0, 1, 0, O_IDLE);
    drive("re_ready", 1, 1, 1, 0, O_READY);
    drive("re_run", 1, 1, 1, 0, O_RUN);

    // Cup removed on the same edge as V=1 -> FAULT
    drive("cup_out_v", 1, 0, 1, 1, O_FAULT);
    drive("fault_s_held", 1, 0, 1, 0, O_FAULT);
    drive("fault_s_held2", 1, 0, 1, 1, O_FAULT);
    drive("fault_clear", 1, 0, 0, 0, O_IDLE);

    // Cup removed during RUN without V, FAULT holds with C=1 S=0
    drive("cr_ready", 1, 1, 0, 0, O_READY);
    drive("cr_run", 1, 1, 1, 0, O_RUN);
    drive("cr_fault", 1, 0, 0, 0, O_FAULT);
    drive("cr_fault_c", 1, 1, 0, 0, O_FAULT);
    drive("cr_idle", 1, 0, 0, 0, O_IDLE);

    // Timeout: M high for exactly RT cycles
    drive("to_ready", 1, 1, 0, 0, O_READY);
    drive("to_run0", 1, 1, 1, 0, O_RUN);
    for (int i = 1; i < int'(RT); i++) drive("to_run", 1, 1, 0, 0, O_RUN);
    drive("to_fault", 1, 1, 0, 0, O_FAULT);
    drive("to_fault_hold", 1, 1, 0, 0, O_FAULT);
    drive("to_idle", 1, 0, 0, 0, O_IDLE);

    // V=1 on RUN entry is ignored until the next edge
    drive("ve_ready", 1, 1, 0, 1, O_READY);
    drive("ve_run", 1, 1, 1, 1, O_RUN);
    drive("ve_done", 1, 1, 1, 1, O_DONE);
    drive("ve_idle", 1, 0, 0, 0, O_IDLE);

    // Reset mid-RUN, then a fresh run gets the full timeout
    drive("rr_ready", 1, 1, 0, 0, O_READY);
    drive("rr_run0", 1, 1, 1, 0, O_RUN);
    drive("rr_run1", 1, 1, 0, 0, O_RUN);
    drive("rr_run2", 1, 1, 0, 0, O_RUN);
    drive("rr_reset", 0, 1, 1, 0, O_IDLE);
    drive("rr_ready2", 1, 1, 1, 0, O_READY);
    drive("rr_run_new", 1, 1, 1, 0, O_RUN);
    for (int i = 1; i < int'(RT); i++) drive("rr_run_full", 1, 1, 0, 0, O_RUN);
    drive("rr_fault", 1, 1, 0, 0, O_FAULT);
    drive("rr_idle", 1, 0, 0, 0, O_IDLE);

    repeat (3) @(negedge clk);
    check("sb_drain", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
